// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// status and a synchronous flush. Read data is registered, so it appears one
// cycle after an accepted read.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     invalid,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              invalid_q, invalid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_ok, wr_ok;

  // Flags are pure decodes of the registered count, so they never lag it.
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign data_out     = data_out_q;
  assign invalid      = invalid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accept/reject decisions and next-state for pointers, count and status;
  // a flush suppresses both requests and wipes the status bits.
  always_comb begin
    rd_ok       = rd_en & ~empty & ~clear;
    wr_ok       = wr_en & (~full | rd_ok) & ~clear;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    invalid_d   = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (rd_ok) begin
        data_out_d = mem[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
      end
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      invalid_d   = (rd_en & ~rd_ok) | (wr_en & ~wr_ok);
      overflow_d  = overflow_q | (wr_en & ~wr_ok);
      underflow_d = underflow_q | (rd_en & ~rd_ok);
    end
  end

  // Storage array is deliberately left out of reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // Control and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      invalid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      invalid_q   <= invalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
